// File: rtl/alu_input_sequencer_pkg.sv
// Shared types and constants for the ALU front-end sequencer.
//  seq_state_t : sequencer FSM states, value equals the state_o LED code
//  OP_*        : 4-bit ALU op codes as set on {SW1,SW0,PB3,PB2}
package alu_io_pkg;

   typedef enum logic [2:0] {
      LOAD_A = 3'd0,
      LOAD_B = 3'd1,
      LOAD_F = 3'd2,
      EXEC   = 3'd3,
      SHOW   = 3'd4
   } seq_state_t;

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_SUB = 4'b0001;
   localparam logic [3:0] OP_MUL = 4'b0100;
   localparam logic [3:0] OP_DIV = 4'b0101;
   localparam logic [3:0] OP_MOD = 4'b0110;
   localparam logic [3:0] OP_AND = 4'b1000;
   localparam logic [3:0] OP_OR  = 4'b1001;
   localparam logic [3:0] OP_XOR = 4'b1010;
   localparam logic [3:0] OP_SHL = 4'b1100;
   localparam logic [3:0] OP_SHR = 4'b1101;

endpackage

// File: rtl/alu_input_sequencer_if.sv
// Board/ALU-side bus of the sequencer.
//  master : the sequencer (reads switches and ALU outputs, drives operands and display)
//  slave  : the board switches plus the ALU (drive sw/op_sw/alu_r/alu_cnvz)
interface alu_input_sequencer_if #(
   parameter int unsigned M = 4
);
   logic [M-1:0] sw;
   logic [3:0]   op_sw;
   logic [M-1:0] alu_a;
   logic [M-1:0] alu_b;
   logic [3:0]   alu_f;
   logic [M-1:0] alu_r;
   logic [3:0]   alu_cnvz;
   logic [M-1:0] res_r;
   logic [3:0]   res_cnvz;
   logic         res_valid;
   logic [2:0]   state_o;

   modport master (
      input  sw, op_sw, alu_r, alu_cnvz,
      output alu_a, alu_b, alu_f, res_r, res_cnvz, res_valid, state_o
   );

   modport slave (
      output sw, op_sw, alu_r, alu_cnvz,
      input  alu_a, alu_b, alu_f, res_r, res_cnvz, res_valid, state_o
   );
endinterface

// File: rtl/alu_input_sequencer_btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stability counter and press pulse.
//  clk, rst_n : system clock, synchronous active-low reset
//  btn_n      : raw active-low button, asynchronous to clk
//  press_p    : one-cycle pulse when a press (released->pressed) is accepted
// A level is accepted once the synchronised input has differed from the accepted
// level for DEB_CYCLES consecutive cycles; press-to-pulse latency is 2 + DEB_CYCLES.
module btn_debounce #(
   parameter int unsigned DEB_CYCLES = 50000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_n,
   output logic press_p
);
   localparam int unsigned     CNT_W    = $clog2(DEB_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

   logic [1:0]       sync_q, sync_d;
   logic             lvl_q, lvl_d;     // accepted level, 1 = released
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             armed_q, armed_d; // a release has been seen since reset
   logic             raw_s;

   assign raw_s = sync_q[1];

   always_comb begin
      sync_d  = {sync_q[0], btn_n};
      lvl_d   = lvl_q;
      cnt_d   = '0;
      armed_d = armed_q | raw_s;
      press_p = 1'b0;
      if (raw_s != lvl_q) begin
         if (cnt_q == CNT_LAST) begin
            lvl_d   = raw_s;
            // A button held through reset is accepted as pressed silently;
            // only a press following an observed release produces a pulse.
            press_p = armed_q & ~raw_s;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // The synchroniser keeps sampling through reset so that armed reflects the
   // real button level as soon as reset is released.
   always_ff @(posedge clk) begin
      sync_q <= sync_d;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lvl_q   <= 1'b1;
         cnt_q   <= '0;
         armed_q <= 1'b0;
      end else begin
         lvl_q   <= lvl_d;
         cnt_q   <= cnt_d;
         armed_q <= armed_d;
      end
   end
endmodule

// File: rtl/alu_input_sequencer.sv
// ALU front-end: loads A, B and F from switches on debounced presses, drives them
// to the ALU and latches the ALU result and flags for display.
//  clk, rst_n             : system clock, synchronous active-low reset
//  btn_next_n, btn_clr_n  : raw active-low buttons (load/advance, clear)
//  bus (master)           : sw/op_sw in, alu_a/b/f out, alu_r/alu_cnvz in,
//                           res_r/res_cnvz/res_valid/state_o out
module alu_input_sequencer
   import alu_io_pkg::*;
#(
   parameter int unsigned M          = 4,
   parameter int unsigned DEB_CYCLES = 50000
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    btn_next_n,
   input  logic                    btn_clr_n,
   alu_input_sequencer_if.master   bus
);
   logic next_p, clr_p;

   btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_next (
      .clk     (clk),
      .rst_n   (rst_n),
      .btn_n   (btn_next_n),
      .press_p (next_p)
   );

   btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clr (
      .clk     (clk),
      .rst_n   (rst_n),
      .btn_n   (btn_clr_n),
      .press_p (clr_p)
   );

   seq_state_t   state_q, state_d;
   logic [M-1:0] a_q, a_d, b_q, b_d, r_q, r_d;
   logic [3:0]   f_q, f_d, cnvz_q, cnvz_d;
   logic         valid_q, valid_d;

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      f_d     = f_q;
      r_d     = r_q;
      cnvz_d  = cnvz_q;
      valid_d = valid_q;
      if (clr_p) begin
         // Clear has priority; a coincident next_p is dropped.
         state_d = LOAD_A;
         a_d     = '0;
         b_d     = '0;
         f_d     = '0;
         r_d     = '0;
         cnvz_d  = '0;
         valid_d = 1'b0;
      end else begin
         unique case (state_q)
            LOAD_A: if (next_p) begin a_d = bus.sw;    state_d = LOAD_B; end
            LOAD_B: if (next_p) begin b_d = bus.sw;    state_d = LOAD_F; end
            LOAD_F: if (next_p) begin f_d = bus.op_sw; state_d = EXEC;   end
            // alu_f was registered last cycle, so the ALU output has settled.
            EXEC: begin
               r_d     = bus.alu_r;
               cnvz_d  = bus.alu_cnvz;
               valid_d = 1'b1;
               state_d = SHOW;
            end
            SHOW: if (next_p) begin valid_d = 1'b0; state_d = LOAD_A; end
            default: state_d = LOAD_A;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= LOAD_A;
         a_q     <= '0;
         b_q     <= '0;
         f_q     <= '0;
         r_q     <= '0;
         cnvz_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         f_q     <= f_d;
         r_q     <= r_d;
         cnvz_q  <= cnvz_d;
         valid_q <= valid_d;
      end
   end

   assign bus.alu_a     = a_q;
   assign bus.alu_b     = b_q;
   assign bus.alu_f     = f_q;
   assign bus.res_r     = r_q;
   assign bus.res_cnvz  = cnvz_q;
   assign bus.res_valid = valid_q;
   assign bus.state_o   = state_q;
endmodule

// File: tb/tb_alu_input_sequencer.sv
module tb_alu_input_sequencer;
   import alu_io_pkg::*;

   localparam int unsigned DEB = 4;

   logic clk = 1'b0;
   logic rst_n;
   logic btn_next_n;
   logic btn_clr_n;

   alu_input_sequencer_if #(.M(4)) bus ();

   alu_input_sequencer #(.M(4), .DEB_CYCLES(DEB)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .btn_next_n (btn_next_n),
      .btn_clr_n  (btn_clr_n),
      .bus        (bus)
   );

   always #5 clk = ~clk;

   // Behavioural 4-bit ALU: returns {r[3:0], C, N, V, Z}.
   function automatic logic [7:0] alu_ref(input logic [3:0] a, input logic [3:0] b,
                                          input logic [3:0] f);
      logic [4:0] w;
      logic [3:0] r;
      logic       c, v;
      w = '0; r = '0; c = 1'b0; v = 1'b0;
      case (f)
         OP_ADD: begin w = {1'b0, a} + {1'b0, b}; r = w[3:0]; c = w[4];
                       v = (a[3] == b[3]) && (r[3] != a[3]); end
         OP_SUB: begin w = {1'b0, a} - {1'b0, b}; r = w[3:0]; c = w[4];
                       v = (a[3] != b[3]) && (r[3] != a[3]); end
         OP_MUL: r = a * b;
         OP_DIV: r = (b == 4'd0) ? 4'hF : a / b;
         OP_MOD: r = (b == 4'd0) ? a : a % b;
         OP_AND: r = a & b;
         OP_OR:  r = a | b;
         OP_XOR: r = a ^ b;
         OP_SHL: r = a << b[1:0];
         OP_SHR: r = a >> b[1:0];
         default: r = '0;
      endcase
      return {r, c, r[3], v, (r == 4'd0)};
   endfunction

   always_comb {bus.alu_r, bus.alu_cnvz} = alu_ref(bus.alu_a, bus.alu_b, bus.alu_f);

   int n_vec = 0;
   int n_err = 0;

   // Reference model of what the sequencer should be showing.
   logic [3:0] m_a, m_b, m_f, m_r, m_c;
   logic       m_v;
   seq_state_t m_st;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".a"},     bus.alu_a,     m_a);
      chk({tag, ".b"},     bus.alu_b,     m_b);
      chk({tag, ".f"},     bus.alu_f,     m_f);
      chk({tag, ".r"},     bus.res_r,     m_r);
      chk({tag, ".cnvz"},  bus.res_cnvz,  m_c);
      chk({tag, ".valid"}, bus.res_valid, m_v);
      chk({tag, ".state"}, bus.state_o,   m_st);
   endtask

   task automatic model_clear();
      m_a = '0; m_b = '0; m_f = '0; m_r = '0; m_c = '0; m_v = 1'b0; m_st = LOAD_A;
   endtask

   // One accepted button event; returns 1 if an execute cycle follows.
   task automatic model_event(input logic nxt, input logic clr, output logic exec);
      exec = 1'b0;
      if (clr) model_clear();
      else if (nxt) begin
         case (m_st)
            LOAD_A: begin m_a = bus.sw;    m_st = LOAD_B; end
            LOAD_B: begin m_b = bus.sw;    m_st = LOAD_F; end
            LOAD_F: begin m_f = bus.op_sw; m_st = EXEC; exec = 1'b1; end
            SHOW:   begin m_v = 1'b0;      m_st = LOAD_A; end
            default: ;
         endcase
      end
   endtask

   // Press the selected buttons, check nothing moves before 2+DEB edges, check
   // the advance on edge 2+DEB, then release and let the release settle.
   task automatic press(input logic nxt, input logic clr, input string tag);
      logic ex;
      @(negedge clk);
      if (nxt) btn_next_n = 1'b0;
      if (clr) btn_clr_n  = 1'b0;
      repeat (DEB + 1) @(negedge clk);
      check_all({tag, ".early"});
      @(negedge clk);
      model_event(nxt, clr, ex);
      check_all({tag, ".adv"});
      if (ex) begin
         @(negedge clk);
         {m_r, m_c} = alu_ref(m_a, m_b, m_f);
         m_v  = 1'b1;
         m_st = SHOW;
         check_all({tag, ".exec"});
      end
      btn_next_n = 1'b1;
      btn_clr_n  = 1'b1;
      repeat (DEB + 4) @(negedge clk);
      check_all({tag, ".rel"});
   endtask

   task automatic load3(input logic [3:0] a, input logic [3:0] b, input logic [3:0] f);
      bus.sw = a;    press(1'b1, 1'b0, "ldA");
      bus.sw = b;    press(1'b1, 1'b0, "ldB");
      bus.op_sw = f; press(1'b1, 1'b0, "ldF");
   endtask

   logic [3:0] ops [10] = '{OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOD,
                            OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR};

   initial begin
      rst_n      = 1'b0;
      btn_next_n = 1'b0;
      btn_clr_n  = 1'b0;
      bus.sw     = 4'h9;
      bus.op_sw  = OP_OR;
      model_clear();

      // 1: reset with both buttons held; held buttons must not advance afterwards
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      check_all("reset");
      repeat (4 * DEB) @(negedge clk);
      check_all("held");
      btn_next_n = 1'b1;
      btn_clr_n  = 1'b1;
      repeat (DEB + 4) @(negedge clk);
      check_all("released");

      // 2: 3 + 5
      load3(4'd3, 4'd5, OP_ADD);
      chk("add.r", bus.res_r, 32'd8);
      chk("add.valid", bus.res_valid, 32'd1);
      chk("add.state", bus.state_o, 32'd4);

      // 3: reload cycles
      press(1'b1, 1'b0, "back");
      load3(4'hC, 4'h5, OP_AND);
      chk("and.r", bus.res_r, 32'h4);
      press(1'b1, 1'b0, "back");
      load3(4'h2, 4'h2, OP_SUB);
      chk("sub.r", bus.res_r, 32'h0);
      chk("sub.z", bus.res_cnvz[0], 32'h1);

      // 4: bouncing next button, then a single clean advance
      press(1'b1, 1'b0, "back");
      bus.sw = 4'hA;
      for (int i = 0; i < 5; i++) begin
         btn_next_n = 1'b0;
         repeat (2) @(negedge clk);
         chk("bounce.lo", bus.state_o, m_st);
         btn_next_n = 1'b1;
         repeat (2) @(negedge clk);
         chk("bounce.hi", bus.state_o, m_st);
      end
      press(1'b1, 1'b0, "settle");
      chk("bounce.one", bus.state_o, 32'd1);

      // 5: next and clear together in LOAD_F
      bus.sw = 4'h6;
      press(1'b1, 1'b0, "ldB");
      chk("pre5.state", bus.state_o, 32'd2);
      press(1'b1, 1'b1, "both");
      chk("both.state", bus.state_o, 32'd0);
      chk("both.a", bus.alu_a, 32'd0);
      chk("both.b", bus.alu_b, 32'd0);
      chk("both.f", bus.alu_f, 32'd0);
      chk("both.valid", bus.res_valid, 32'd0);

      // 6: switches moving in SHOW have no effect; next returns to LOAD_A keeping A
      load3(4'h7, 4'h3, OP_MUL);
      bus.sw    = 4'hF;
      bus.op_sw = OP_XOR;
      repeat (5) @(negedge clk);
      check_all("show.hold");
      chk("show.r", bus.res_r, 32'h5);
      press(1'b1, 1'b0, "exit");
      chk("exit.valid", bus.res_valid, 32'd0);
      chk("exit.state", bus.state_o, 32'd0);
      chk("exit.a", bus.alu_a, 32'h7);

      // Randomised presses and occasional clears
      for (int k = 0; k < 40; k++) begin
         bus.sw    = 4'($urandom);
         bus.op_sw = ops[$urandom_range(0, 9)];
         if ($urandom_range(0, 7) == 0) press(1'b0, 1'b1, "rnd.clr");
         else                           press(1'b1, 1'b0, "rnd.next");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
